// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: queued update record and 2-bit PHT counter.
package btb_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic        predicted;
   } btb_update_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pht_ctr_t;

   // Saturating 2-bit counter step toward the resolved outcome.
   function automatic pht_ctr_t pht_next(input pht_ctr_t ctr, input logic taken);
      pht_ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ST) nxt = pht_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) nxt = pht_ctr_t'(ctr - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO of resolved-branch updates; head is read combinationally.
module btb_update_fifo
   import btb_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        wr_en,
   input  btb_update_t wr_data,
   input  logic        rd_en,
   output btb_update_t rd_data,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

   btb_update_t     mem [QDEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_wr;
   logic            do_rd;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // full is judged before this cycle's read, so a pop never frees a slot the same cycle
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/btb_update_unit.sv
// Buffers resolved branches, drains one per cycle into the PHT and BTB write port,
// and serves the fetch-stage taken/not-taken prediction.
module btb_update_unit
   import btb_pkg::*;
#(
   parameter int INDEX_BITS = 11,
   parameter int QDEPTH     = 4
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  resolve_valid,
   output logic                  resolve_ready,
   input  logic [31:0]           resolve_pc,
   input  logic                  resolve_taken,
   input  logic [31:0]           resolve_target,
   input  logic                  predicted_taken,
   input  logic                  drain_stall,
   input  logic [31:0]           fetch_pc,
   output logic                  predict_taken,
   output logic                  btb_wen,
   output logic [INDEX_BITS-1:0] btb_index,
   output logic [31:0]           btb_wdat,
   output logic [31:0]           mispredict_count
);

   localparam int PHT_SIZE = 2**INDEX_BITS;

   btb_update_t           enq_entry;
   btb_update_t           head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  drain;
   logic [INDEX_BITS-1:0] head_idx;
   logic [INDEX_BITS-1:0] fetch_idx;
   pht_ctr_t              pht [PHT_SIZE];
   pht_ctr_t              ctr_new;
   logic [1:0]            fetch_ctr;
   logic                  unused_bits;

   assign enq_entry = '{pc: resolve_pc, target: resolve_target,
                        taken: resolve_taken, predicted: predicted_taken};

   btb_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .wr_en   (resolve_valid),
      .wr_data (enq_entry),
      .rd_en   (~drain_stall),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign resolve_ready = ~fifo_full;
   assign drain         = ~fifo_empty & ~drain_stall;
   assign head_idx      = head.pc[INDEX_BITS+1:2];
   assign fetch_idx     = fetch_pc[INDEX_BITS+1:2];
   assign ctr_new       = pht_next(pht[head_idx], head.taken);

   // Prediction reads committed state only; a same-cycle drain is visible next cycle.
   assign fetch_ctr     = pht[fetch_idx];
   assign predict_taken = fetch_ctr[1];

   assign unused_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                          head.pc[31:INDEX_BITS+2], head.pc[1:0]};

   // Index 0 is never written to the BTB; a zero write data word means evict.
   always_comb begin
      btb_wen   = 1'b0;
      btb_wdat  = '0;
      btb_index = fifo_empty ? '0 : head_idx;
      if (drain && head_idx != '0) begin
         if (head.taken) begin
            btb_wen  = 1'b1;
            btb_wdat = head.target;
         end else if (ctr_new == SNT) begin
            btb_wen  = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < PHT_SIZE; i++) pht[i] <= WNT;
      end else if (drain) begin
         pht[head_idx] <= ctr_new;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         mispredict_count <= '0;
      end else if (drain && (head.taken != head.predicted)) begin
         mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule
